// File: rtl/bus_err_drain_ctrl.sv
// Drains stored bus-error entries from an error unit over a register bus and streams them out.
// Latency: 4 cycles from err_irq_i to log_valid_o with the register bus always ready.
// Backpressure: register requests hold until ready; log beat holds until log_ready_i; one reg txn in flight.

package bus_err_drain_pkg;
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;
endpackage

module bus_err_drain_ctrl #(
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned MetaDataWidth = 1,
    parameter int unsigned ErrBits       = 1,
    parameter logic [31:0] ErrCodeOffset = 32'h0,
    parameter logic [31:0] ErrAddrOffset = 32'h4,
    parameter logic [31:0] ErrMetaOffset = 32'h8,
    parameter logic [31:0] PopOffset     = 32'hC,
    parameter type         reg_req_t     = bus_err_drain_pkg::reg_req_t,
    parameter type         reg_rsp_t     = bus_err_drain_pkg::reg_rsp_t
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     enable_i,
    input  logic                     err_irq_i,
    output reg_req_t                 reg_req_o,
    input  reg_rsp_t                 reg_rsp_i,
    output logic                     log_valid_o,
    input  logic                     log_ready_i,
    output logic [AddrWidth-1:0]     log_addr_o,
    output logic [MetaDataWidth-1:0] log_meta_o,
    output logic [ErrBits-1:0]       log_err_o,
    output logic [15:0]              drained_cnt_o,
    output logic                     reg_err_o,
    output logic                     busy_o
);

    typedef enum logic [2:0] {
        IDLE, RD_CODE, RD_ADDR, RD_META, OUT, POP, HALT
    } state_e;

    state_e                   state_q, state_d;
    reg_req_t                 req_q;
    logic                     log_valid_q;
    logic                     busy_q;
    logic                     reg_err_q;
    logic [ErrBits-1:0]       code_q;
    logic [AddrWidth-1:0]     addr_q;
    logic [MetaDataWidth-1:0] meta_q;
    logic [15:0]              drained_cnt_q;

    logic hs;
    logic rsp_err;

    // Register-bus request presented while sitting in a given state; constant per state,
    // so registering it on state entry keeps it stable until the handshake moves us on.
    function automatic reg_req_t req_for(state_e s);
        reg_req_t r;
        r = '0;
        case (s)
            RD_CODE: begin
                r.valid = 1'b1;
                r.addr  = ErrCodeOffset;
            end
            RD_ADDR: begin
                r.valid = 1'b1;
                r.addr  = ErrAddrOffset;
            end
            RD_META: begin
                r.valid = 1'b1;
                r.addr  = ErrMetaOffset;
            end
            POP: begin
                r.valid    = 1'b1;
                r.write    = 1'b1;
                r.addr     = PopOffset;
                r.wdata[0] = 1'b1;
                r.wstrb    = '1;
            end
            default: ;
        endcase
        return r;
    endfunction

    assign hs      = req_q.valid & reg_rsp_i.ready;
    assign rsp_err = hs & reg_rsp_i.error;

    // Next-state decision; any erroring response overrides the normal path and parks in HALT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i && err_irq_i && !reg_err_q) state_d = RD_CODE;
            RD_CODE: if (hs) state_d = (reg_rsp_i.rdata[ErrBits-1:0] == '0) ? IDLE : RD_ADDR;
            RD_ADDR: if (hs) state_d = RD_META;
            RD_META: if (hs) state_d = OUT;
            OUT:     if (log_ready_i) state_d = POP;
            POP:     if (hs) state_d = (enable_i && err_irq_i) ? RD_CODE : IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        if (rsp_err) state_d = HALT;
    end

    // State, registered outputs, captured entry fields and counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            req_q         <= '0;
            log_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            reg_err_q     <= 1'b0;
            code_q        <= '0;
            addr_q        <= '0;
            meta_q        <= '0;
            drained_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_for(state_d);
            log_valid_q <= (state_d == OUT);
            busy_q      <= (state_d != IDLE);
            if (rsp_err) begin
                // A failed access leaves the entry half-read; drop what was captured.
                reg_err_q <= 1'b1;
                code_q    <= '0;
                addr_q    <= '0;
                meta_q    <= '0;
            end else if (hs) begin
                case (state_q)
                    RD_CODE: if (reg_rsp_i.rdata[ErrBits-1:0] != '0)
                                 code_q <= reg_rsp_i.rdata[ErrBits-1:0];
                    RD_ADDR: addr_q <= reg_rsp_i.rdata[AddrWidth-1:0];
                    RD_META: meta_q <= reg_rsp_i.rdata[MetaDataWidth-1:0];
                    POP:     if (drained_cnt_q != 16'hFFFF)
                                 drained_cnt_q <= drained_cnt_q + 16'd1;
                    default: ;
                endcase
            end
        end
    end

    assign reg_req_o     = req_q;
    assign log_valid_o   = log_valid_q;
    assign log_addr_o    = addr_q;
    assign log_meta_o    = meta_q;
    assign log_err_o     = code_q;
    assign drained_cnt_o = drained_cnt_q;
    assign reg_err_o     = reg_err_q;
    assign busy_o        = busy_q;

endmodule
